// File: rtl/feature_streamer.sv
// ============================================================================
// feature_streamer: streams N_INPUTS words from a synchronous RAM to a
// consumer, one word per 3 cycles, with hold_i backpressure.
// Revision: 1.0
// ============================================================================
`default_nettype none

module feature_streamer #(
  parameter int          ADDR_WIDTH = 16,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          DATA_WIDTH = 32,
  parameter int          N_INPUTS   = 784
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  hold_i,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [ADDR_WIDTH-1:0] ram_rdaddress_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int                    CW     = $clog2(N_INPUTS + 1);
  localparam logic [ADDR_WIDTH-1:0] c_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CW-1:0]         c_LAST = CW'(N_INPUTS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LATCH   = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                r_state, w_state_n;
  logic [CW-1:0]         r_count, w_count_n;
  logic [ADDR_WIDTH-1:0] r_addr,  w_addr_n;
  logic [DATA_WIDTH-1:0] r_data,  w_data_n;
  logic                  r_valid, w_valid_n;
  logic                  r_busy,  w_busy_n;
  logic                  r_done,  w_done_n;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_addr  <= c_BASE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  // Outputs are registered from their next values, so the DONE-state
  // outputs (done pulse, busy low, address rewound) appear while in DONE.
  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_addr_n  = r_addr;
    w_data_n  = r_data;
    w_valid_n = r_valid;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_state_n = S_LATCH;
      end
      S_LATCH: begin
        w_data_n  = ram_data_i;
        w_valid_n = 1'b1;
        w_state_n = S_PRESENT;
      end
      S_PRESENT: begin
        if (r_valid && !hold_i) begin
          w_valid_n = 1'b0;
          if (r_count == c_LAST) begin
            w_count_n = '0;
            w_addr_n  = c_BASE;
            w_busy_n  = 1'b0;
            w_done_n  = 1'b1;
            w_state_n = S_DONE;
          end else begin
            w_count_n = r_count + 1'b1;
            w_addr_n  = r_addr + 1'b1;
            w_state_n = S_FETCH;
          end
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        // IDLE, and any illegal encoding behaves as IDLE
        w_state_n = S_IDLE;
        if (start_i) begin
          w_count_n = '0;
          w_addr_n  = c_BASE;
          w_busy_n  = 1'b1;
          w_state_n = S_FETCH;
        end
      end
    endcase
  end

  assign ram_rdaddress_o = r_addr;
  assign data_o          = r_data;
  assign data_valid_o    = r_valid;
  assign busy_o          = r_busy;
  assign done_o          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_feature_streamer.sv
// Bench for feature_streamer: three instances (base 8 / N=4, base 0xFFFE / N=4,
// base 8 / N=1) share stimulus; a transaction-level model checks every cycle.
`default_nettype none

module tb_feature_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, hold;
  logic [31:0] rdA, rdB, rdC, dA, dB, dC;
  logic [15:0] aA, aB, aC;
  logic vA, vB, vC, bA, bB, bC, oA, oB, oC;

  int checks = 0;
  int errors = 0;

  feature_streamer #(.ADDR_WIDTH(16), .BASE_ADDR(8), .DATA_WIDTH(32), .N_INPUTS(4)) u_a (
    .clock_i(clk), .reset_i(rst), .start_i(start), .hold_i(hold), .ram_data_i(rdA),
    .ram_rdaddress_o(aA), .data_o(dA), .data_valid_o(vA), .busy_o(bA), .done_o(oA));

  feature_streamer #(.ADDR_WIDTH(16), .BASE_ADDR(16'hFFFE), .DATA_WIDTH(32), .N_INPUTS(4)) u_b (
    .clock_i(clk), .reset_i(rst), .start_i(start), .hold_i(hold), .ram_data_i(rdB),
    .ram_rdaddress_o(aB), .data_o(dB), .data_valid_o(vB), .busy_o(bB), .done_o(oB));

  feature_streamer #(.ADDR_WIDTH(16), .BASE_ADDR(8), .DATA_WIDTH(32), .N_INPUTS(1)) u_c (
    .clock_i(clk), .reset_i(rst), .start_i(start), .hold_i(hold), .ram_data_i(rdC),
    .ram_rdaddress_o(aC), .data_o(dC), .data_valid_o(vC), .busy_o(bC), .done_o(oC));

  function automatic logic [31:0] ram_word(input int sel, input logic [15:0] a);
    case (sel)
      0:       return (a >= 16'd8 && a <= 16'd11) ? 32'(a - 16'd7) : {16'hA5A5, a};
      1:       return {16'hB00B, a};
      default: return (a == 16'd8) ? 32'hDEADBEEF : {16'hC0DE, a};
    endcase
  endfunction

  always @(posedge clk) begin
    rdA <= ram_word(0, aA);
    rdB <= ram_word(1, aB);
    rdC <= ram_word(2, aC);
  end

  // Reference model: a frame is a list of words; word k is offered
  // 2 edges after the frame start or the previous transfer.
  typedef struct packed {
    bit          busy;
    bit          valid;
    bit          done;
    int          idx;
    int          delay;
    logic [31:0] data;
    logic [15:0] addr;
  } model_t;

  function automatic model_t mstep(input model_t m, input bit r, input bit st, input bit hd,
                                   input int n, input int base, input int sel);
    model_t q = m;
    if (r) begin
      q.busy = 0; q.valid = 0; q.done = 0; q.idx = 0; q.delay = 0;
      q.data = '0; q.addr = 16'(base);
    end else if (m.done) begin
      q.done = 0;
    end else if (!m.busy) begin
      if (st) begin
        q.busy = 1; q.idx = 0; q.delay = 2; q.addr = 16'(base);
      end
    end else if (m.valid) begin
      if (!hd) begin
        q.valid = 0;
        if (m.idx == n - 1) begin
          q.busy = 0; q.done = 1; q.idx = 0; q.addr = 16'(base);
        end else begin
          q.idx = m.idx + 1; q.delay = 2; q.addr = 16'(base + q.idx);
        end
      end
    end else begin
      q.delay = m.delay - 1;
      if (q.delay == 0) begin
        q.valid = 1;
        q.data  = ram_word(sel, 16'(base + m.idx));
      end
    end
    return q;
  endfunction

  model_t mA, mB, mC;
  always @(posedge clk) begin
    mA <= mstep(mA, rst, start, hold, 4, 8, 0);
    mB <= mstep(mB, rst, start, hold, 4, 32'hFFFE, 1);
    mC <= mstep(mC, rst, start, hold, 1, 8, 2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("mA.addr", 32'(aA), 32'(mA.addr));
    chk("mA.data", dA, mA.data);
    chk("mA.valid", 32'(vA), 32'(mA.valid));
    chk("mA.busy", 32'(bA), 32'(mA.busy));
    chk("mA.done", 32'(oA), 32'(mA.done));
    chk("mB.addr", 32'(aB), 32'(mB.addr));
    chk("mB.data", dB, mB.data);
    chk("mB.valid", 32'(vB), 32'(mB.valid));
    chk("mB.busy", 32'(bB), 32'(mB.busy));
    chk("mB.done", 32'(oB), 32'(mB.done));
    chk("mC.addr", 32'(aC), 32'(mC.addr));
    chk("mC.data", dC, mC.data);
    chk("mC.valid", 32'(vC), 32'(mC.valid));
    chk("mC.busy", 32'(bC), 32'(mC.busy));
    chk("mC.done", 32'(oC), 32'(mC.done));
  end

  typedef struct packed {
    bit          st;
    logic [15:0] a_addr;
    bit          a_v;
    logic [31:0] a_d;
    bit          a_b;
    bit          a_done;
    logic [15:0] b_addr;
    bit          c_v;
    logic [31:0] c_d;
    bit          c_done;
  } vec_t;

  vec_t tbl [14];

  task automatic wait_valid_data(input string nm, input logic [31:0] want);
    int k = 0;
    while (!(vA === 1'b1 && dA === want) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(k < 60), 32'd1);
  endtask

  task automatic wait_done_a(input string nm);
    int k = 0;
    while (oA !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(k < 60), 32'd1);
  endtask

  initial begin
    int hold_run;
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.addr", 32'(aA), 32'd8);
    chk("rst.valid", 32'(vA), 32'd0);
    chk("rst.data", dA, 32'd0);
    chk("rst.busy", 32'(bA), 32'd0);
    chk("rst.done", 32'(oA), 32'd0);
    chk("rst.b_addr", 32'(aB), 32'h0000FFFE);

    //         st addr    v  data           b  dn  b_addr      cv  c_data         cdn
    tbl[0]  = '{1, 16'd8,  0, 32'd0, 1, 0, 16'hFFFE, 0, 32'd0,        0};
    tbl[1]  = '{0, 16'd8,  0, 32'd0, 1, 0, 16'hFFFE, 0, 32'd0,        0};
    tbl[2]  = '{0, 16'd8,  1, 32'd1, 1, 0, 16'hFFFE, 1, 32'hDEADBEEF, 0};
    tbl[3]  = '{0, 16'd9,  0, 32'd1, 1, 0, 16'hFFFF, 0, 32'hDEADBEEF, 1};
    tbl[4]  = '{0, 16'd9,  0, 32'd1, 1, 0, 16'hFFFF, 0, 32'hDEADBEEF, 0};
    tbl[5]  = '{0, 16'd9,  1, 32'd2, 1, 0, 16'hFFFF, 0, 32'hDEADBEEF, 0};
    tbl[6]  = '{0, 16'd10, 0, 32'd2, 1, 0, 16'h0000, 0, 32'hDEADBEEF, 0};
    tbl[7]  = '{0, 16'd10, 0, 32'd2, 1, 0, 16'h0000, 0, 32'hDEADBEEF, 0};
    tbl[8]  = '{0, 16'd10, 1, 32'd3, 1, 0, 16'h0000, 0, 32'hDEADBEEF, 0};
    tbl[9]  = '{0, 16'd11, 0, 32'd3, 1, 0, 16'h0001, 0, 32'hDEADBEEF, 0};
    tbl[10] = '{0, 16'd11, 0, 32'd3, 1, 0, 16'h0001, 0, 32'hDEADBEEF, 0};
    tbl[11] = '{0, 16'd11, 1, 32'd4, 1, 0, 16'h0001, 0, 32'hDEADBEEF, 0};
    tbl[12] = '{0, 16'd8,  0, 32'd4, 0, 1, 16'hFFFE, 0, 32'hDEADBEEF, 0};
    tbl[13] = '{0, 16'd8,  0, 32'd4, 0, 0, 16'hFFFE, 0, 32'hDEADBEEF, 0};

    for (int i = 0; i < 14; i++) begin
      start = tbl[i].st;
      @(negedge clk);
      chk($sformatf("tbl%0d.a_addr", i), 32'(aA), 32'(tbl[i].a_addr));
      chk($sformatf("tbl%0d.a_valid", i), 32'(vA), 32'(tbl[i].a_v));
      chk($sformatf("tbl%0d.a_data", i), dA, tbl[i].a_d);
      chk($sformatf("tbl%0d.a_busy", i), 32'(bA), 32'(tbl[i].a_b));
      chk($sformatf("tbl%0d.a_done", i), 32'(oA), 32'(tbl[i].a_done));
      chk($sformatf("tbl%0d.b_addr", i), 32'(aB), 32'(tbl[i].b_addr));
      chk($sformatf("tbl%0d.c_valid", i), 32'(vC), 32'(tbl[i].c_v));
      chk($sformatf("tbl%0d.c_data", i), dC, tbl[i].c_d);
      chk($sformatf("tbl%0d.c_done", i), 32'(oC), 32'(tbl[i].c_done));
    end

    // Long hold on the second word
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid_data("hold.reach_word2", 32'd2);
    hold = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("hold.valid", 32'(vA), 32'd1);
      chk("hold.data", dA, 32'd2);
      chk("hold.addr", 32'(aA), 32'd9);
    end
    hold = 1'b0;
    @(negedge clk);
    chk("hold.xfer_valid", 32'(vA), 32'd0);
    chk("hold.xfer_addr", 32'(aA), 32'd10);
    wait_done_a("hold.done");
    @(negedge clk);

    // start held high across a frame and its DONE
    start = 1'b1;
    wait_done_a("start_held.done");
    @(negedge clk);
    chk("start_held.idle_busy", 32'(bA), 32'd0);
    @(negedge clk);
    chk("start_held.restart_busy", 32'(bA), 32'd1);
    start = 1'b0;
    wait_done_a("start_held.done2");
    @(negedge clk);

    // Reset while the third word is presented; start during reset is lost
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid_data("rst_mid.reach_word3", 32'd3);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_mid.addr", 32'(aA), 32'd8);
    chk("rst_mid.valid", 32'(vA), 32'd0);
    chk("rst_mid.data", dA, 32'd0);
    chk("rst_mid.busy", 32'(bA), 32'd0);
    chk("rst_mid.done", 32'(oA), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_mid.start_lost", 32'(bA), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid_data("rst_mid.replay_word1", 32'd1);
    chk("rst_mid.replay_addr", 32'(aA), 32'd8);
    wait_done_a("rst_mid.done");

    // Randomized traffic, checked every cycle by the model
    hold_run = 0;
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 5) == 0);
      if (hold_run > 0) begin
        hold = 1'b1;
        hold_run--;
      end else if ($urandom_range(0, 39) == 0) begin
        hold_run = int'($urandom_range(5, 20));
        hold = 1'b1;
      end else begin
        hold = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
    end

    rst = 1'b0; start = 1'b0; hold = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
